stack_drain: RTL and testbench



---
 rtl/stack_drain.sv | 140 ++++++++++++++
 tb/tb_stack_drain.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_drain.sv
// Reader-side sequencer for the LIFO symbol stack: pops symbols one at a time,
// packs them into words and hands the words downstream over valid/ready.
module stack_drain #(
  parameter int DATA_WIDTH = 2,
  parameter int PACK       = 4,
  parameter int CNT_W      = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [CNT_W-1:0]           count_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       underrun_o,
  output logic                       stk_pop_o,
  input  logic [DATA_WIDTH-1:0]      stk_data_i,
  input  logic                       stk_empty_i,
  output logic [PACK*DATA_WIDTH-1:0] out_data_o,
  output logic [2:0]                 out_nsym_o,
  output logic                       out_last_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  typedef enum logic [1:0] {IDLE, POP, CAPTURE, EMIT} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          rem_q, rem_d;
  logic                      countMode_q, countMode_d;
  logic [2:0]                nsym_q, nsym_d;
  logic [PACK*DATA_WIDTH-1:0] buf_q, buf_d;
  logic                      last_q, last_d;
  logic                      underrun_q, underrun_d;
  logic                      done_q, done_d;
  logic                      capLast;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      countMode_q <= 1'b0;
      nsym_q      <= '0;
      buf_q       <= '0;
      last_q      <= 1'b0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      countMode_q <= countMode_d;
      nsym_q      <= nsym_d;
      buf_q       <= buf_d;
      last_q      <= last_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    countMode_d = countMode_q;
    nsym_d      = nsym_q;
    buf_d       = buf_q;
    last_d      = last_q;
    underrun_d  = underrun_q;
    done_d      = 1'b0;
    capLast     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          rem_d       = count_i;
          countMode_d = (count_i != '0);
          underrun_d  = 1'b0;
          nsym_d      = '0;
          buf_d       = '0;
          last_d      = 1'b0;
          state_d     = POP;
        end
      end

      POP: begin
        if (stk_empty_i) begin
          // Running dry in count mode always means fewer symbols than requested.
          if (countMode_q) underrun_d = 1'b1;
          if (nsym_q != 3'd0) begin
            last_d  = 1'b1;
            state_d = EMIT;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        for (int i = 0; i < PACK; i++) begin
          if (nsym_q == 3'(i)) buf_d[i*DATA_WIDTH +: DATA_WIDTH] = stk_data_i;
        end
        nsym_d = nsym_q + 3'd1;
        if (countMode_q) rem_d = rem_q - CNT_W'(1);
        // The empty flag already reflects the pop that produced this symbol.
        capLast = (countMode_q && (rem_q == CNT_W'(1))) || stk_empty_i;
        last_d  = capLast;
        if (stk_empty_i && countMode_q && (rem_q > CNT_W'(1))) underrun_d = 1'b1;
        if (capLast || (nsym_d == 3'(PACK))) state_d = EMIT;
        else                                 state_d = POP;
      end

      EMIT: begin
        if (out_ready_i) begin
          buf_d  = '0;
          nsym_d = '0;
          if (last_q) begin
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = POP;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign underrun_o  = underrun_q;
  assign stk_pop_o   = (state_q == POP) && !stk_empty_i;
  assign out_valid_o = (state_q == EMIT);
  assign out_data_o  = buf_q;
  assign out_nsym_o  = nsym_q;
  assign out_last_o  = last_q;

endmodule

// File: tb/tb_stack_drain.sv
// Table-driven bench for stack_drain with a behavioural LIFO model on the stack side,
// plus hand-written sequences for timing, backpressure and mid-drain reset.
module tb_stack_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] count;
  logic       busy, done, underrun, stkPop;
  logic [1:0] stkData = 2'd0;
  logic       stkEmpty = 1'b1;
  logic [7:0] outData;
  logic [2:0] outNsym;
  logic       outLast, outValid;
  logic       outReady;

  logic       stkClr = 1'b0;
  logic       pushEn = 1'b0;
  logic [1:0] pushVal = 2'd0;
  logic [1:0] mem [64];
  int         sp = 0;
  int         badPop = 0;

  int total = 0;
  int bad   = 0;

  stack_drain #(.DATA_WIDTH(2), .PACK(4), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .count_i(count),
    .busy_o(busy), .done_o(done), .underrun_o(underrun), .stk_pop_o(stkPop),
    .stk_data_i(stkData), .stk_empty_i(stkEmpty),
    .out_data_o(outData), .out_nsym_o(outNsym), .out_last_o(outLast),
    .out_valid_o(outValid), .out_ready_i(outReady)
  );

  always #5 clk = ~clk;

  // LIFO model: read data appears the cycle after a pop, empty flag is registered.
  always @(posedge clk) begin
    if (stkClr) begin
      sp <= 0;
      stkEmpty <= 1'b1;
    end else if (pushEn) begin
      mem[6'(sp)] <= pushVal;
      sp <= sp + 1;
      stkEmpty <= 1'b0;
    end else if (stkPop) begin
      if (stkEmpty || sp == 0) badPop <= badPop + 1;
      else begin
        stkData  <= mem[6'(sp - 1)];
        sp       <= sp - 1;
        stkEmpty <= (sp == 1);
      end
    end
  end

  typedef struct {
    logic [15:0] syms;
    int          nPush;
    logic [5:0]  cnt;
    int          nWords;
    logic [7:0]  d0, d1;
    logic [2:0]  n0, n1;
    logic        l0, l1;
    logic        und;
    int          doneCyc;
  } vec_t;

  vec_t tbl [7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearStack();
    stkClr = 1'b1;
    step();
    stkClr = 1'b0;
  endtask

  task automatic pushSyms(input logic [15:0] syms, input int n);
    for (int i = 0; i < n; i++) begin
      pushEn  = 1'b1;
      pushVal = syms[2*i +: 2];
      step();
    end
    pushEn = 1'b0;
  endtask

  task automatic applyStimulus(input logic [5:0] cnt);
    start = 1'b1;
    count = cnt;
    step();
    start = 1'b0;
  endtask

  // Called in cycle n+1; returns words seen and the cycle index of DONE.
  task automatic collect(output int nw, output logic [7:0] d0, output logic [7:0] d1,
                         output logic [2:0] n0, output logic [2:0] n1,
                         output logic l0, output logic l1, output int doneCyc);
    int c;
    nw = 0; d0 = 0; d1 = 0; n0 = 0; n1 = 0; l0 = 0; l1 = 0; doneCyc = 0;
    c = 1;
    while (doneCyc == 0 && c < 200) begin
      if (outValid && outReady) begin
        if (nw == 0) begin d0 = outData; n0 = outNsym; l0 = outLast; end
        else if (nw == 1) begin d1 = outData; n1 = outNsym; l1 = outLast; end
        nw++;
      end
      if (done) doneCyc = c;
      else begin
        step();
        c++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, dc;
    logic [7:0] d0, d1, hold;
    logic [2:0] n0, n1;
    logic l0, l1;
    logic [15:0] popMask;
    int validCyc, unstable, popSeen, waitCnt;

    tbl[0] = '{syms:16'h001B, nPush:4, cnt:6'd4, nWords:1, d0:8'hE4, d1:8'h00,
               n0:3'd4, n1:3'd0, l0:1'b1, l1:1'b0, und:1'b0, doneCyc:10};
    tbl[1] = '{syms:16'h0E55, nPush:6, cnt:6'd0, nWords:2, d0:8'h5B, d1:8'h05,
               n0:3'd4, n1:3'd2, l0:1'b0, l1:1'b1, und:1'b0, doneCyc:15};
    tbl[2] = '{syms:16'h000E, nPush:2, cnt:6'd5, nWords:1, d0:8'h0B, d1:8'h00,
               n0:3'd2, n1:3'd0, l0:1'b1, l1:1'b0, und:1'b1, doneCyc:6};
    tbl[3] = '{syms:16'h0000, nPush:0, cnt:6'd0, nWords:0, d0:8'h00, d1:8'h00,
               n0:3'd0, n1:3'd0, l0:1'b0, l1:1'b0, und:1'b0, doneCyc:2};
    tbl[4] = '{syms:16'h0000, nPush:0, cnt:6'd3, nWords:0, d0:8'h00, d1:8'h00,
               n0:3'd0, n1:3'd0, l0:1'b0, l1:1'b0, und:1'b1, doneCyc:2};
    tbl[5] = '{syms:16'h04E4, nPush:6, cnt:6'd3, nWords:1, d0:8'h31, d1:8'h00,
               n0:3'd3, n1:3'd0, l0:1'b1, l1:1'b0, und:1'b0, doneCyc:8};
    tbl[6] = '{syms:16'h3939, nPush:8, cnt:6'd8, nWords:2, d0:8'h6C, d1:8'h6C,
               n0:3'd4, n1:3'd4, l0:1'b0, l1:1'b1, und:1'b0, doneCyc:19};

    rst = 1'b1; start = 1'b0; count = '0; outReady = 1'b1;
    step();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset underrun", underrun, 0);
    checkOutput("reset pop", stkPop, 0);
    checkOutput("reset valid", outValid, 0);
    checkOutput("reset last", outLast, 0);
    checkOutput("reset nsym", outNsym, 0);
    checkOutput("reset data", outData, 0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      clearStack();
      pushSyms(tbl[v].syms, tbl[v].nPush);
      applyStimulus(tbl[v].cnt);
      checkOutput($sformatf("v%0d busy after start", v), busy, 1);
      checkOutput($sformatf("v%0d underrun cleared", v), underrun, 0);
      collect(nw, d0, d1, n0, n1, l0, l1, dc);
      checkOutput($sformatf("v%0d done cycle", v), dc, tbl[v].doneCyc);
      checkOutput($sformatf("v%0d words", v), nw, tbl[v].nWords);
      if (tbl[v].nWords > 0) begin
        checkOutput($sformatf("v%0d w0 data", v), d0, tbl[v].d0);
        checkOutput($sformatf("v%0d w0 nsym", v), n0, tbl[v].n0);
        checkOutput($sformatf("v%0d w0 last", v), l0, tbl[v].l0);
      end
      if (tbl[v].nWords > 1) begin
        checkOutput($sformatf("v%0d w1 data", v), d1, tbl[v].d1);
        checkOutput($sformatf("v%0d w1 nsym", v), n1, tbl[v].n1);
        checkOutput($sformatf("v%0d w1 last", v), l1, tbl[v].l1);
      end
      checkOutput($sformatf("v%0d underrun", v), underrun, tbl[v].und);
      step(); step(); step();
      checkOutput($sformatf("v%0d underrun sticky", v), underrun, tbl[v].und);
      checkOutput($sformatf("v%0d idle busy", v), busy, 0);
    end

    // Pop and valid timing for a full four-symbol word.
    clearStack();
    pushSyms(16'h001B, 4);
    applyStimulus(6'd4);
    popMask = '0; validCyc = 0; dc = 0;
    for (int c = 1; c <= 12; c++) begin
      if (stkPop) popMask[c] = 1'b1;
      if (outValid && validCyc == 0) validCyc = c;
      if (done && dc == 0) dc = c;
      step();
    end
    checkOutput("timing pop cycles", popMask, 16'h00AA);
    checkOutput("timing valid cycle", validCyc, 9);
    checkOutput("timing done cycle", dc, 10);

    // Backpressure with an ignored START while the word is held.
    clearStack();
    pushSyms(16'h00E4, 4);
    outReady = 1'b0;
    applyStimulus(6'd0);
    waitCnt = 0;
    while (!outValid && waitCnt < 50) begin
      step();
      waitCnt++;
    end
    checkOutput("bp valid reached", outValid, 1);
    hold = outData; unstable = 0; popSeen = 0;
    for (int k = 0; k < 10; k++) begin
      start = (k == 3);
      count = 6'd1;
      step();
      if (outData !== hold || outNsym !== 3'd4 || outLast !== 1'b1 || !outValid) unstable++;
      if (stkPop) popSeen++;
    end
    start = 1'b0;
    checkOutput("bp held stable", unstable, 0);
    checkOutput("bp no pops", popSeen, 0);
    checkOutput("bp data", outData, 8'h1B);
    outReady = 1'b1;
    collect(nw, d0, d1, n0, n1, l0, l1, dc);
    checkOutput("bp words after release", nw, 1);
    checkOutput("bp done seen", dc != 0, 1);
    checkOutput("bp underrun", underrun, 0);
    step();
    checkOutput("bp start ignored", busy, 0);
    checkOutput("bp stack drained", sp, 0);

    // Reset asserted while capturing the second symbol.
    clearStack();
    pushSyms(16'h09E4, 6);
    applyStimulus(6'd0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst valid", outValid, 0);
    checkOutput("midrst pop", stkPop, 0);
    checkOutput("midrst nsym", outNsym, 0);
    checkOutput("midrst data", outData, 0);
    checkOutput("midrst done", done, 0);
    checkOutput("midrst stack left", sp, 4);
    applyStimulus(6'd0);
    collect(nw, d0, d1, n0, n1, l0, l1, dc);
    checkOutput("midrst words", nw, 1);
    checkOutput("midrst data2", d0, 8'h1B);
    checkOutput("midrst nsym2", n0, 4);
    checkOutput("midrst last2", l0, 1);

    checkOutput("pop while empty", badPop, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
